// File: rtl/ca_prng_pkg.sv
// Shared types and helpers for the cellular-automaton random word stream.
// Holds the controller state encoding, the Wolfram rule lookup and default word geometry.
package ca_prng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fsm_e;

    localparam int DEF_N    = 16;
    localparam int DEF_TAPS = 2;
    localparam int STEPS    = DEF_N / DEF_TAPS;

    // Wolfram numbering: the neighbourhood {left, centre, right} indexes the rule byte.
    function automatic logic apply_rule(input logic [7:0] rule, input logic l,
                                        input logic c, input logic r);
        return rule[{l, c, r}];
    endfunction

endpackage

// File: rtl/ca_prng_stream_array.sv
// Hybrid radius-1 cellular automaton: cell register plus next-state logic.
// Each cell uses RULE_B where RULE_MASK is set, RULE_A otherwise; boundary is null or periodic.
module ca_hybrid_array
    import ca_prng_pkg::*;
#(
    parameter int                     ARRAY_WIDTH = 32,
    parameter logic [7:0]             RULE_A      = 8'd30,
    parameter logic [7:0]             RULE_B      = 8'd150,
    parameter logic [ARRAY_WIDTH-1:0] RULE_MASK   = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_load,
    input  logic [ARRAY_WIDTH-1:0] i_seed,
    input  logic                   i_step,
    input  logic                   i_periodic,
    output logic [ARRAY_WIDTH-1:0] o_state,
    output logic [ARRAY_WIDTH-1:0] o_next
);

    // A zero seed would lock the automaton, so it is replaced by a single centre cell.
    localparam logic [ARRAY_WIDTH-1:0] ZERO_SEED_FIX =
        {{(ARRAY_WIDTH-1){1'b0}}, 1'b1} << (ARRAY_WIDTH / 2);

    logic [ARRAY_WIDTH-1:0] cells_q;
    logic [ARRAY_WIDTH-1:0] cells_d;
    logic [ARRAY_WIDTH+1:0] ext_s;
    logic [ARRAY_WIDTH-1:0] next_s;

    // Neighbour-padded view of the array so every cell sees {c[i+1], c[i], c[i-1]}.
    always_comb begin
        ext_s  = {i_periodic & cells_q[0], cells_q, i_periodic & cells_q[ARRAY_WIDTH-1]};
        next_s = '0;
        for (int i = 0; i < ARRAY_WIDTH; i++) begin
            if (RULE_MASK[i]) begin
                next_s[i] = apply_rule(RULE_B, ext_s[i+2], ext_s[i+1], ext_s[i]);
            end else begin
                next_s[i] = apply_rule(RULE_A, ext_s[i+2], ext_s[i+1], ext_s[i]);
            end
        end
    end

    // Seed load wins over a step.
    always_comb begin
        if (i_load) begin
            cells_d = (|i_seed) ? i_seed : ZERO_SEED_FIX;
        end else if (i_step) begin
            cells_d = next_s;
        end else begin
            cells_d = cells_q;
        end
    end

    // Cell register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cells_q <= '0;
        end else begin
            cells_q <= cells_d;
        end
    end

    assign o_state = cells_q;
    assign o_next  = next_s;

endmodule

// File: rtl/ca_prng_stream.sv
// Streaming random word generator: seed handshake, step control, tap harvesting,
// word shifter with valid/ready output and a sticky all-zero detector.
module ca_prng_stream
    import ca_prng_pkg::*;
#(
    parameter int                     ARRAY_WIDTH = 32,
    parameter int                     N           = 16,
    parameter int                     TAPS        = 2,
    parameter int                     LOC0        = ARRAY_WIDTH / 2,
    parameter int                     TAP_STRIDE  = 3,
    parameter logic [7:0]             RULE_A      = 8'd30,
    parameter logic [7:0]             RULE_B      = 8'd150,
    parameter logic [ARRAY_WIDTH-1:0] RULE_MASK   = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_seed_valid,
    input  logic [ARRAY_WIDTH-1:0] i_seed,
    output logic                   o_seed_ready,
    input  logic                   i_enable,
    input  logic                   i_periodic,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [N-1:0]           o_rn,
    output logic [ARRAY_WIDTH-1:0] o_state,
    output logic                   o_stuck
);

    localparam int WORD_STEPS = N / TAPS;
    localparam int CW         = (WORD_STEPS > 1) ? $clog2(WORD_STEPS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WORD_STEPS - 1);

    fsm_e                   fsm_q, fsm_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          base_s;
    logic [N-1:0]           rn_q, rn_d;
    logic [N+TAPS-1:0]      rn_cat_s;
    logic                   valid_q, valid_d;
    logic                   stuck_q, stuck_d;
    logic                   step_s;
    logic [TAPS-1:0]        tap_s;
    logic [ARRAY_WIDTH-1:0] state_s;
    logic [ARRAY_WIDTH-1:0] next_s;

    ca_hybrid_array #(
        .ARRAY_WIDTH (ARRAY_WIDTH),
        .RULE_A      (RULE_A),
        .RULE_B      (RULE_B),
        .RULE_MASK   (RULE_MASK)
    ) u_array (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (i_seed_valid),
        .i_seed     (i_seed),
        .i_step     (step_s),
        .i_periodic (i_periodic),
        .o_state    (state_s),
        .o_next     (next_s)
    );

    for (genvar t = 0; t < TAPS; t++) begin : g_tap
        localparam int TAP_IDX = (LOC0 + t * TAP_STRIDE) % ARRAY_WIDTH;
        assign tap_s[t] = next_s[TAP_IDX];
    end

    assign step_s   = !i_seed_valid && i_enable &&
                      ((fsm_q == ST_RUN) || ((fsm_q == ST_HOLD) && i_ready));
    // A step out of HOLD is the first step of a fresh word.
    assign base_s   = (fsm_q == ST_HOLD) ? {CW{1'b0}} : cnt_q;
    assign rn_cat_s = {tap_s, rn_q};

    // Controller next state: seed load, step, consume-only, or hold.
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        rn_d    = rn_q;
        valid_d = valid_q;
        stuck_d = stuck_q;
        if (i_seed_valid) begin
            fsm_d   = ST_RUN;
            cnt_d   = {CW{1'b0}};
            rn_d    = {N{1'b0}};
            valid_d = 1'b0;
            stuck_d = 1'b0;
        end else if (step_s) begin
            rn_d    = rn_cat_s[N+TAPS-1:TAPS];
            stuck_d = stuck_q | ~(|next_s);
            if (base_s == LAST_CNT) begin
                fsm_d   = ST_HOLD;
                cnt_d   = {CW{1'b0}};
                valid_d = 1'b1;
            end else begin
                fsm_d   = ST_RUN;
                cnt_d   = base_s + CW'(1);
                valid_d = 1'b0;
            end
        end else if ((fsm_q == ST_HOLD) && i_ready) begin
            fsm_d   = ST_RUN;
            cnt_d   = {CW{1'b0}};
            valid_d = 1'b0;
        end else begin
            fsm_d   = fsm_q;
        end
    end

    // Controller and output registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            fsm_q   <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            rn_q    <= {N{1'b0}};
            valid_q <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            rn_q    <= rn_d;
            valid_q <= valid_d;
            stuck_q <= stuck_d;
        end
    end

    assign o_seed_ready = i_rst;
    assign o_valid      = valid_q;
    assign o_rn         = rn_q;
    assign o_state      = state_s;
    assign o_stuck      = stuck_q;

endmodule

// File: tb/tb_ca_prng_stream.sv
// Bench for ca_prng_stream: two configurations driven in lockstep, directed steps
// followed by random traffic, all compared against a behavioural word-level model.
module tb_ca_prng_stream;

    typedef struct packed {
        logic [63:0] st;
        logic [63:0] rn;
        logic [1:0]  phase;   // 0 waiting for seed, 1 building word, 2 word held
        logic [7:0]  cnt;
        logic        valid;
        logic        stuck;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_valid = 1'b0;
    logic        enable = 1'b0;
    logic        periodic = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  seed_a = 8'h00;
    logic [15:0] seed_b = 16'h0000;

    logic        sr_a, sr_b, valid_a, valid_b, stuck_a, stuck_b;
    logic [2:0]  rn_a;
    logic [7:0]  rn_b;
    logic [7:0]  state_a;
    logic [15:0] state_b;

    int   checks = 0;
    int   errors = 0;
    mdl_t ma, mb;

    always #5 clk = ~clk;

    ca_prng_stream #(
        .ARRAY_WIDTH(8), .N(3), .TAPS(1), .LOC0(4), .TAP_STRIDE(3),
        .RULE_A(8'd30), .RULE_B(8'd150), .RULE_MASK(8'h00)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_seed_valid(seed_valid), .i_seed(seed_a),
        .o_seed_ready(sr_a), .i_enable(enable), .i_periodic(periodic),
        .o_valid(valid_a), .i_ready(ready), .o_rn(rn_a), .o_state(state_a),
        .o_stuck(stuck_a)
    );

    ca_prng_stream #(
        .ARRAY_WIDTH(16), .N(8), .TAPS(2), .LOC0(5), .TAP_STRIDE(7),
        .RULE_A(8'd90), .RULE_B(8'd60), .RULE_MASK(16'hA5C3)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_seed_valid(seed_valid), .i_seed(seed_b),
        .o_seed_ready(sr_b), .i_enable(enable), .i_periodic(periodic),
        .o_valid(valid_b), .i_ready(ready), .o_rn(rn_b), .o_state(state_b),
        .o_stuck(stuck_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ca_ref(input logic [63:0] s, input int aw, input int ra,
                                           input int rb, input logic [63:0] mask, input bit per);
        logic [63:0] r;
        int lb, rbit, idx, rule;
        r = 64'd0;
        for (int i = 0; i < aw; i++) begin
            lb   = (i + 1 < aw) ? int'(s[i+1]) : (per ? int'(s[0]) : 0);
            rbit = (i > 0) ? int'(s[i-1]) : (per ? int'(s[aw-1]) : 0);
            idx  = lb * 4 + int'(s[i]) * 2 + rbit;
            rule = mask[i] ? rb : ra;
            r[i] = ((rule >> idx) & 1) != 0;
        end
        return r;
    endfunction

    function automatic mdl_t model_reset();
        mdl_t m;
        m = '0;
        return m;
    endfunction

    function automatic mdl_t model_next(input mdl_t mi, input int d, input logic [63:0] seed,
                                        input bit sv, input bit en, input bit rdy, input bit per);
        mdl_t m;
        int aw, n, tp, loc0, str, ra, rb, steps;
        logic [63:0] mask, nxt, tw;
        bit do_step;
        m = mi;
        do_step = 1'b0;
        case (d)
            0:       begin aw = 8;  n = 3; tp = 1; loc0 = 4; str = 3; ra = 30; rb = 150; mask = 64'h0; end
            default: begin aw = 16; n = 8; tp = 2; loc0 = 5; str = 7; ra = 90; rb = 60;  mask = 64'hA5C3; end
        endcase
        steps = n / tp;
        if (sv) begin
            m.st    = (seed == 64'd0) ? (64'd1 << (aw / 2)) : seed;
            m.rn    = 64'd0;
            m.cnt   = 8'd0;
            m.valid = 1'b0;
            m.stuck = 1'b0;
            m.phase = 2'd1;
        end else if (m.phase == 2'd1 && en) begin
            do_step = 1'b1;
        end else if (m.phase == 2'd2 && rdy) begin
            m.valid = 1'b0;
            m.phase = 2'd1;
            m.cnt   = 8'd0;
            do_step = en;
        end
        if (do_step) begin
            nxt = ca_ref(m.st, aw, ra, rb, mask, per);
            tw  = 64'd0;
            for (int t = 0; t < tp; t++) tw[t] = nxt[(loc0 + t * str) % aw];
            m.rn = (m.rn >> tp) | (tw << (n - tp));
            if (nxt == 64'd0) m.stuck = 1'b1;
            m.st  = nxt;
            m.cnt = m.cnt + 8'd1;
            if (int'(m.cnt) == steps) begin
                m.valid = 1'b1;
                m.phase = 2'd2;
                m.cnt   = 8'd0;
            end
        end
        return m;
    endfunction

    task automatic check_all();
        chk("a_state", {56'd0, state_a}, ma.st);
        chk("a_rn",    {61'd0, rn_a},    ma.rn);
        chk("a_valid", {63'd0, valid_a}, {63'd0, ma.valid});
        chk("a_stuck", {63'd0, stuck_a}, {63'd0, ma.stuck});
        chk("b_state", {48'd0, state_b}, mb.st);
        chk("b_rn",    {56'd0, rn_b},    mb.rn);
        chk("b_valid", {63'd0, valid_b}, {63'd0, mb.valid});
        chk("b_stuck", {63'd0, stuck_b}, {63'd0, mb.stuck});
    endtask

    task automatic tick();
        ma = model_next(ma, 0, {56'd0, seed_a}, seed_valid, enable, ready, periodic);
        mb = model_next(mb, 1, {48'd0, seed_b}, seed_valid, enable, ready, periodic);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b0;
        #1;
        ma = model_reset();
        mb = model_reset();
        check_all();
        chk("seed_ready_in_reset", {63'd0, sr_a}, 64'd0);
        #10 rst = 1'b1;
        #1;
        chk("seed_ready_out_of_reset", {62'd0, sr_b, sr_a}, 64'd3);

        // IDLE ignores enable
        enable = 1'b1;
        tick();
        chk("idle_no_step", {56'd0, state_a}, 64'h0);

        // Step check, null boundary, rule 30
        seed_a = 8'h10; seed_b = 16'h0421; seed_valid = 1'b1;
        tick();
        chk("seed_visible", {56'd0, state_a}, 64'h10);
        seed_valid = 1'b0;
        tick(); chk("step1", {56'd0, state_a}, 64'h38);
        tick(); chk("step2", {56'd0, state_a}, 64'h64);
        chk("step2_no_valid", {63'd0, valid_a}, 64'd0);
        tick(); chk("step3", {56'd0, state_a}, 64'hDE);
        chk("word_101", {61'd0, rn_a}, 64'd5);
        chk("valid_on_3rd", {63'd0, valid_a}, 64'd1);

        // Backpressure for five cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_state", {56'd0, state_a}, 64'hDE);
            chk("bp_rn", {61'd0, rn_a}, 64'd5);
        end
        ready = 1'b1;
        tick();
        chk("consume_valid_falls", {63'd0, valid_a}, 64'd0);

        // Periodic versus null boundary
        seed_a = 8'h01; periodic = 1'b1; seed_valid = 1'b1;
        tick(); seed_valid = 1'b0;
        tick(); chk("periodic_step", {56'd0, state_a}, 64'h83);
        periodic = 1'b0; seed_valid = 1'b1;
        tick(); seed_valid = 1'b0;
        tick(); chk("null_step", {56'd0, state_a}, 64'h03);

        // Zero seed substitution and mid-word reseed on the 4-step word
        ready = 1'b0; seed_a = 8'h00; seed_b = 16'h0000; seed_valid = 1'b1;
        tick();
        chk("zero_seed_a", {56'd0, state_a}, 64'h10);
        chk("zero_seed_b", {48'd0, state_b}, 64'h0100);
        seed_valid = 1'b0;
        tick();
        seed_b = 16'h5A3C; seed_valid = 1'b1;
        tick();
        chk("reseed_rn_clear", {56'd0, rn_b}, 64'd0);
        seed_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reseed_not_yet_valid", {63'd0, valid_b}, 64'd0);
        end
        tick();
        chk("reseed_valid_after_4", {63'd0, valid_b}, 64'd1);

        // All-zero state from the linear hybrid rules: sticky flag
        ready = 1'b1; periodic = 1'b1; seed_b = 16'hFFFF; seed_valid = 1'b1;
        tick(); seed_valid = 1'b0;
        tick();
        chk("stuck_state_zero", {48'd0, state_b}, 64'd0);
        chk("stuck_set", {63'd0, stuck_b}, 64'd1);
        tick();
        chk("stuck_sticky", {63'd0, stuck_b}, 64'd1);
        seed_b = 16'h1234; seed_valid = 1'b1;
        tick();
        chk("stuck_cleared_by_seed", {63'd0, stuck_b}, 64'd0);
        seed_valid = 1'b0;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            seed_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 5))
                0:       begin seed_a = 8'h00; seed_b = 16'h0000; end
                1:       begin seed_a = 8'hFF; seed_b = 16'hFFFF; end
                default: begin seed_a = 8'($urandom); seed_b = 16'($urandom); end
            endcase
            enable   = ($urandom_range(0, 4) != 0);
            ready    = 1'($urandom);
            periodic = 1'($urandom);
            tick();
        end

        // Asynchronous reset while a word is held
        seed_a = 8'h5B; seed_b = 16'hC0DE; seed_valid = 1'b1; enable = 1'b1; ready = 1'b0;
        tick(); seed_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("hold_before_reset", {62'd0, valid_b, valid_a}, 64'd3);
        rst = 1'b0;
        #1;
        ma = model_reset();
        mb = model_reset();
        check_all();
        tick();
        rst = 1'b1;
        tick();
        chk("idle_after_reset", {48'd0, state_b}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ca_prng_stream.md
# ca_prng_stream

Streaming pseudo-random word generator built on a parametrised 1-D cellular automaton with radius-1 neighbourhoods. It generalises the single-tap CA generator in four ways: a per-cell hybrid rule (two rules selected by a mask), a runtime null or periodic boundary, multi-tap harvesting, and a seed/output handshake. It sits between the entropy and seeding logic upstream and any valid/ready consumer of random words downstream.

## Interface
- ARRAY_WIDTH, 32, number of CA cells; must be ≥ 3.
- N, 16, output word width.
- TAPS, 2, bits harvested per CA step; N % TAPS must be 0.
- LOC0, ARRAY_WIDTH/2, cell index of tap 0.
- TAP_STRIDE, 3, tap i reads cell (LOC0 + i*TAP_STRIDE) % ARRAY_WIDTH.
- RULE_A, 30, 8-bit Wolfram rule for cells whose mask bit is 0.
- RULE_B, 150, 8-bit Wolfram rule for cells whose mask bit is 1.
- RULE_MASK, '0, ARRAY_WIDTH-bit per-cell rule select.

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  reset; asynchronous, active-low.
- i_seed_valid  in  1  seed load request.
- i_seed  in  ARRAY_WIDTH  seed value.
- o_seed_ready  out  1  seed accept; tied to 1 while out of reset.
- i_enable  in  1  step enable.
- i_periodic  in  1  boundary mode: 1 = wrap-around, 0 = null (zero) boundary.
- o_valid  out  1  o_rn holds a complete word.
- i_ready  in  1  consumer accept.
- o_rn  out  N  random word.
- o_state  out  ARRAY_WIDTH  current CA state.
- o_stuck  out  1  sticky flag: CA state is all-zero.

## Operation
- FSM states:
  - IDLE: after reset, waiting for a seed.
  - RUN: accumulating a word.
  - HOLD: word valid and not yet consumed.
- Reset values: state, o_rn, word counter, o_valid and o_stuck are all 0; FSM = IDLE.
- Cell update rule:
  - Cell i next value = rule[{c[i+1], c[i], c[i-1]}], where rule is RULE_B if RULE_MASK[i] is 1, else RULE_A.
  - Out-of-range neighbours are 0 when i_periodic = 0.
  - With i_periodic = 1, the neighbours wrap: c[ARRAY_WIDTH] = c[0] and c[-1] = c[ARRAY_WIDTH-1].
- Step condition: a step occurs on an edge where FSM = RUN and i_enable = 1, or FSM = HOLD and i_ready = 1 and i_enable = 1.
- Harvest and shift on each step:
  - Harvest is taken from the next-state value of each tap cell.
  - Shift: o_rn <= {tap[TAPS-1..0], o_rn[N-1:TAPS]}, with tap TAPS-1 at the MSB.
- Word completion:
  - The word counter counts 0..N/TAPS-1.
  - The step that completes a word sets o_valid and enters HOLD.
  - A step taken in HOLD consumes the word, clears o_valid, starts the next word with count 1, and returns to RUN.
  - HOLD with i_ready = 1 and i_enable = 0: the word is consumed, o_valid clears, the state returns to RUN with count 0, and no step is taken.
- Seed load (any state):
  - Loads i_seed into the array, clears o_rn, the counter, o_valid and o_stuck, and enters RUN.
  - A seed load has priority over a step or consume on the same edge; that step and consume are discarded.
  - A partial word is discarded.
  - An all-zero seed is loaded as a single 1 at cell ARRAY_WIDTH/2.
- o_stuck:
  - Set on the edge that makes the state all-zero while in RUN or HOLD.
  - Cleared only by a seed load or by reset.
  - Stepping continues while o_stuck is set.
- i_periodic is sampled on every step and may change between steps.

## Timing
- The seed is accepted on the edge where i_seed_valid = 1; o_state shows the seed value after that edge.
- The first step is on the next enabled edge.
- Latency: o_valid rises after N/TAPS enabled steps following the seed edge.
- Throughput: one word per N/TAPS cycles with i_ready held at 1; there are no bubbles.
- o_rn and o_state are stable while o_valid = 1 and i_ready = 0.
- Asserting i_rst mid-word drops o_valid immediately and asynchronously.

## Structure
- Package ca_prng_pkg holds:
  - the FSM state enum;
  - function apply_rule(rule[7:0], l, c, r);
  - constant localparam STEPS = N/TAPS.
- Sub-module ca_hybrid_array holds the cell register and the next-state logic.
  - Inputs: clock, reset, load, seed, step, periodic.
  - Outputs: state and next-state.
- The top level contains the FSM, tap harvesting, the word shifter and the stuck detector.

## Test plan
- Step check, with ARRAY_WIDTH=8, RULE_A=30, null boundary, seed 8'b00010000: states follow 00111000, 01100100, 11011110. With TAPS=1, N=3, LOC0=4, o_rn = 3'b101 and o_valid rises on the 3rd step.
- Periodic boundary: seed 8'b00000001 with i_periodic=1 -> 10000011 after one step; with i_periodic=0 -> 00000011.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid rises -> o_rn and o_state are unchanged. Raising i_ready gives a consume plus a step on the same edge, and o_valid falls.
- Mid-word reseed: seed on the 2nd step of a 4-step word -> o_rn = 0, counter restarts, and o_valid rises only 4 steps later. An all-zero seed loads 8'b00010000.
- Hybrid rule and stuck flag:
  - With RULE_MASK=8'hFF, RULE_B=150 and periodic boundary, seed 8'b00000001 -> 10000011.
  - With RULE_A=0 and RULE_MASK=0, one step -> state 0 and o_stuck=1; the flag clears on reseed.
- Reset mid-HOLD: drop i_rst -> o_valid, o_rn, o_state and o_stuck go to 0 asynchronously, and the FSM is in IDLE.
